// File: rtl/control_pipelined.sv
// control_pipelined: registered, valid/ready instruction decoder producing
// datapath controls for LW, SW and R-type ops, with MUL sequenced as a
// multi-cycle start/done operation guarded by a timeout.
module control_pipelined #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MUL_TIMEOUT = 16,
  parameter logic [5:0]  OP_MAT      = 6'd7,
  parameter logic [5:0]  OP_LW       = 6'd8,
  parameter logic [5:0]  OP_SW       = 6'd9,
  parameter logic [5:0]  F_ADD       = 6'd32,
  parameter logic [5:0]  F_SUB       = 6'd34,
  parameter logic [5:0]  F_AND       = 6'd36,
  parameter logic [5:0]  F_OR        = 6'd37,
  parameter logic [5:0]  F_MUL       = 6'd50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instrIn,
  input  logic                      instrValid,
  output logic                      instrReady,
  input  logic                      stallIn,
  input  logic                      mulDone,
  output logic                      ctrlValid,
  output logic                      selectMux01,
  output logic                      selectMux02,
  output logic                      selectMux03,
  output logic [1:0]                selectALU,
  output logic                      weRAM,
  output logic                      weRegFile,
  output logic                      startMultiplicador,
  output logic [REG_ADDR_W-1:0]     addressRS,
  output logic [REG_ADDR_W-1:0]     addressRT,
  output logic [REG_ADDR_W-1:0]     addressRD,
  output logic                      illegalOp,
  output logic                      mulTimeout,
  output logic [10+3*REG_ADDR_W:0]  controlOut
);

  localparam int unsigned CNT_W = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_MUL_WAIT} state_t;

  // Field order matches the low part of controlOut (MSB first).
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rs;
    logic                  we_rf;
    logic                  mux03;
    logic                  we_ram;
    logic                  mux02;
    logic [1:0]            alu;
    logic                  mux01;
  } fields_t;

  // Idle word: read RAM, mux02 selected, no register write.
  localparam fields_t RST_F = '{rd: '0, rt: '0, rs: '0, we_rf: 1'b0, mux03: 1'b0,
                                we_ram: 1'b1, mux02: 1'b1, alu: 2'b00, mux01: 1'b0};

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  fields_t          r_f, w_f_nxt, w_dec_f;
  logic             r_valid, w_valid_nxt;
  logic             r_illegal, w_illegal_nxt;
  logic             r_start, w_start_nxt;
  logic             r_tmo, w_tmo_nxt;
  logic             w_dec_illegal, w_dec_mul, w_accept;
  logic [5:0]       w_op, w_fn;
  logic [4:0]       w_rs5, w_rt5, w_rd5;
  logic             w_unused;

  assign w_op     = instrIn[31:26];
  assign w_rs5    = instrIn[25:21];
  assign w_rt5    = instrIn[20:16];
  assign w_rd5    = instrIn[15:11];
  assign w_fn     = instrIn[5:0];
  assign w_unused = &{1'b0, instrIn[10:6]};

  assign instrReady = (r_state == S_IDLE) && !stallIn;
  assign w_accept   = instrValid && instrReady;

  // Decode the incoming instruction into a candidate control word.
  always_comb begin
    w_dec_f       = RST_F;
    w_dec_illegal = 1'b0;
    w_dec_mul     = 1'b0;
    case (w_op)
      OP_LW, OP_SW: begin
        w_dec_f.mux01  = 1'b1;
        w_dec_f.mux03  = 1'b1;
        w_dec_f.we_ram = (w_op == OP_LW);
        w_dec_f.we_rf  = (w_op == OP_LW);
        w_dec_f.rs     = w_rs5[REG_ADDR_W-1:0];
        w_dec_f.rt     = w_rt5[REG_ADDR_W-1:0];
        w_dec_f.rd     = w_rt5[REG_ADDR_W-1:0];
      end
      OP_MAT: begin
        w_dec_f.we_rf = 1'b1;
        w_dec_f.rs    = w_rs5[REG_ADDR_W-1:0];
        w_dec_f.rt    = w_rt5[REG_ADDR_W-1:0];
        w_dec_f.rd    = w_rd5[REG_ADDR_W-1:0];
        case (w_fn)
          F_ADD:   w_dec_f.alu = 2'd0;
          F_SUB:   w_dec_f.alu = 2'd1;
          F_AND:   w_dec_f.alu = 2'd2;
          F_OR:    w_dec_f.alu = 2'd3;
          F_MUL: begin
            w_dec_mul     = 1'b1;
            w_dec_f.we_rf = 1'b0;
          end
          default: w_dec_illegal = 1'b1;
        endcase
      end
      default: w_dec_illegal = 1'b1;
    endcase
    if (w_dec_illegal) begin
      w_dec_f = RST_F;
    end
  end

  // Next-state and next-output logic for the IDLE / MUL_WAIT sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_f_nxt       = r_f;
    w_valid_nxt   = r_valid;
    w_illegal_nxt = r_illegal;
    w_start_nxt   = r_start;
    w_tmo_nxt     = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_f_nxt       = w_dec_f;
          w_illegal_nxt = w_dec_illegal;
          w_valid_nxt   = !w_dec_mul;
          w_start_nxt   = w_dec_mul;
          w_tmo_nxt     = 1'b0;
          if (w_dec_mul) begin
            w_state_nxt = S_MUL_WAIT;
            w_cnt_nxt   = '0;
          end
        end else if (!stallIn) begin
          w_valid_nxt   = 1'b0;
          w_illegal_nxt = 1'b0;
          w_start_nxt   = 1'b0;
          w_tmo_nxt     = 1'b0;
        end
      end
      S_MUL_WAIT: begin
        w_valid_nxt   = 1'b0;
        w_illegal_nxt = 1'b0;
        w_start_nxt   = 1'b0;
        w_tmo_nxt     = 1'b0;
        // Done wins over timeout, including on the final counted cycle.
        if (mulDone) begin
          w_valid_nxt    = 1'b1;
          w_f_nxt.mux01  = 1'b0;
          w_f_nxt.mux02  = 1'b0;
          w_f_nxt.mux03  = 1'b0;
          w_f_nxt.alu    = 2'd0;
          w_f_nxt.we_ram = 1'b1;
          w_f_nxt.we_rf  = 1'b1;
          w_state_nxt    = S_IDLE;
          w_cnt_nxt      = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_tmo_nxt     = 1'b1;
          w_f_nxt.we_rf = 1'b0;
          w_state_nxt   = S_IDLE;
          w_cnt_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_f       <= RST_F;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_start   <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_f       <= w_f_nxt;
      r_valid   <= w_valid_nxt;
      r_illegal <= w_illegal_nxt;
      r_start   <= w_start_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

  assign ctrlValid          = r_valid;
  assign illegalOp          = r_illegal;
  assign mulTimeout         = r_tmo;
  assign startMultiplicador = r_start;
  assign selectMux01        = r_f.mux01;
  assign selectMux02        = r_f.mux02;
  assign selectMux03        = r_f.mux03;
  assign selectALU          = r_f.alu;
  assign weRAM              = r_f.we_ram;
  assign weRegFile          = r_f.we_rf;
  assign addressRS          = r_f.rs;
  assign addressRT          = r_f.rt;
  assign addressRD          = r_f.rd;
  assign controlOut         = {3'b000, r_start, r_f};

endmodule
